// File: rtl/cpx_mult_arbiter_pkg.sv
// Shared constants and width helpers for the complex-multiplier arbiter slice.
package cpx_mult_arbiter_pkg;

  localparam int NREQ_MAX = 8;
  localparam int DEF_IL1  = 9;
  localparam int DEF_IL2  = 10;

  // Ceiling log2, written as a bounded loop so it works as a constant function.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Requester-ID width: a single requester still needs a 1-bit field.
  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/cpx_mult_arbiter_if.sv
// Bundles the requester bus, multiplier port and response channel of the arbiter.
interface cpx_mult_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IL1  = cpx_mult_arbiter_pkg::DEF_IL1,
  parameter int IL2  = cpx_mult_arbiter_pkg::DEF_IL2
);
  import cpx_mult_arbiter_pkg::*;

  localparam int OL  = IL1 + IL2;
  localparam int IDW = id_width(NREQ);

  logic                iFLUSH;
  logic [NREQ-1:0]     iREQ_VALID;
  logic [NREQ-1:0]     oREQ_READY;
  logic [NREQ*IL1-1:0] iREQ_re_1;
  logic [NREQ*IL1-1:0] iREQ_im_1;
  logic [NREQ*IL2-1:0] iREQ_re_2;
  logic [NREQ*IL2-1:0] iREQ_im_2;
  logic                oMUL_EN;
  logic                oMUL_CLR;
  logic [IL1-1:0]      oMUL_re_1;
  logic [IL1-1:0]      oMUL_im_1;
  logic [IL2-1:0]      oMUL_re_2;
  logic [IL2-1:0]      oMUL_im_2;
  logic [OL-1:0]       iMUL_re;
  logic [OL-1:0]       iMUL_im;
  logic                oRSP_VALID;
  logic                iRSP_READY;
  logic [IDW-1:0]      oRSP_ID;
  logic [OL-1:0]       oRSP_re;
  logic [OL-1:0]       oRSP_im;

  modport slave (
    input  iFLUSH, iREQ_VALID, iREQ_re_1, iREQ_im_1, iREQ_re_2, iREQ_im_2,
           iMUL_re, iMUL_im, iRSP_READY,
    output oREQ_READY, oMUL_EN, oMUL_CLR, oMUL_re_1, oMUL_im_1, oMUL_re_2,
           oMUL_im_2, oRSP_VALID, oRSP_ID, oRSP_re, oRSP_im
  );

  modport master (
    output iFLUSH, iREQ_VALID, iREQ_re_1, iREQ_im_1, iREQ_re_2, iREQ_im_2,
           iMUL_re, iMUL_im, iRSP_READY,
    input  oREQ_READY, oMUL_EN, oMUL_CLR, oMUL_re_1, oMUL_im_1, oMUL_re_2,
           oMUL_im_2, oRSP_VALID, oRSP_ID, oRSP_re, oRSP_im
  );

endinterface

// File: rtl/cpx_mult_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping, as one-hot plus index.
module cpx_mult_arbiter_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);
  import cpx_mult_arbiter_pkg::*;

  int   pos;
  logic found;

  // Walk the requests starting at ptr and keep only the first one seen.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = 0; i < NREQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/cpx_mult_arbiter.sv
// Shares one registered complex multiplier among NREQ requesters with a
// round-robin grant and a single tagged response channel that takes backpressure.
module cpx_mult_arbiter #(
  parameter int NREQ = 2,
  parameter int IL1  = cpx_mult_arbiter_pkg::DEF_IL1,
  parameter int IL2  = cpx_mult_arbiter_pkg::DEF_IL2
) (
  input  logic              iCLK,
  input  logic              iRST,
  cpx_mult_arbiter_if.slave bus
);
  import cpx_mult_arbiter_pkg::*;

  localparam int IDW = id_width(NREQ);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic            rsp_v_q, rsp_v_d;
  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0]  pick_idx;
  logic [NREQ-1:0] grant;
  logic            adv;
  logic            fire;
  int              sel;

  cpx_mult_arbiter_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req   (bus.iREQ_VALID),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Grant only when the response slot is free or being drained; flush and reset block it.
  always_comb begin
    adv            = ~bus.iFLUSH & ~iRST & (~rsp_v_q | bus.iRSP_READY);
    grant          = adv ? pick_grant : '0;
    fire           = |(bus.iREQ_VALID & grant);
    sel            = fire ? int'(pick_idx) : 0;
    bus.oREQ_READY = grant;
    bus.oMUL_EN    = fire;
    bus.oMUL_CLR   = bus.iFLUSH | iRST;
    bus.oMUL_re_1  = bus.iREQ_re_1[sel*IL1 +: IL1];
    bus.oMUL_im_1  = bus.iREQ_im_1[sel*IL1 +: IL1];
    bus.oMUL_re_2  = bus.iREQ_re_2[sel*IL2 +: IL2];
    bus.oMUL_im_2  = bus.iREQ_im_2[sel*IL2 +: IL2];
    bus.oRSP_VALID = rsp_v_q;
    bus.oRSP_ID    = rsp_id_q;
    bus.oRSP_re    = bus.iMUL_re;
    bus.oRSP_im    = bus.iMUL_im;
  end

  // Next pointer and response state; flush wins over a new fire and over draining.
  always_comb begin
    ptr_d    = ptr_q;
    rsp_v_d  = rsp_v_q;
    rsp_id_d = rsp_id_q;
    if (bus.iFLUSH) begin
      rsp_v_d = 1'b0;
    end else if (fire) begin
      rsp_v_d  = 1'b1;
      rsp_id_d = pick_idx;
      ptr_d    = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    end else if (bus.iRSP_READY) begin
      rsp_v_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ptr_q    <= '0;
      rsp_v_q  <= 1'b0;
      rsp_id_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rsp_v_q  <= rsp_v_d;
      rsp_id_q <= rsp_id_d;
    end
  end

endmodule
